// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the "101" sequence detector: accepts words over valid/ready
// and presents one bit per enabled clock on ser_out. The line stays low when no word bit is shown.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ser_en,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     word_done,
  output logic                     busy
);

  localparam int             IW       = $clog2(WIDTH);
  localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] load_word;
  logic [3:0]       gap_cnt;
  logic             last_bit;
  logic             accept;

  // The register always shifts toward its MSB, so LSB-first words are loaded mirrored.
  if (MSB_FIRST) begin : g_msb_first
    assign load_word = in_data;
  end else begin : g_lsb_first
    always_comb begin
      load_word = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        load_word[i] = in_data[WIDTH-1-i];
      end
    end
  end

  assign last_bit  = (state == SHIFT) && ser_en && (bit_idx == LAST_IDX);
  assign in_ready  = (state == IDLE) || ((GAP_CYCLES == 0) && last_bit);
  assign accept    = in_valid && in_ready;
  assign word_done = last_bit;
  assign busy      = (state != IDLE);
  // Zero fill while shifting leaves the register clear once a word is out, so the MSB is
  // already 0 whenever no word bit is presented.
  assign ser_out   = shreg[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      ser_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg     <= load_word;
            bit_idx   <= '0;
            ser_valid <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            if (last_bit) begin
              if (accept) begin
                shreg     <= load_word;
                bit_idx   <= '0;
                ser_valid <= 1'b1;
                state     <= SHIFT;
              end else begin
                shreg     <= '0;
                bit_idx   <= '0;
                ser_valid <= 1'b0;
                if (GAP_CYCLES > 0) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= GAP;
                end else begin
                  state   <= IDLE;
                end
              end
            end else begin
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          shreg     <= '0;
          bit_idx   <= '0;
          gap_cnt   <= '0;
          ser_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: three instances (MSB-first, LSB-first, 3-cycle gap)
// fed with directed words; a negedge monitor pops hand-written expected bit streams.
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] a_data, b_data, c_data;
  logic       a_valid, b_valid, c_valid;
  logic       a_ready, b_ready, c_ready;
  logic       a_en, b_en, c_en;
  logic       a_so, b_so, c_so;
  logic       a_sv, b_sv, c_sv;
  logic [2:0] a_idx, b_idx, c_idx;
  logic       a_wd, b_wd, c_wd;
  logic       a_busy, b_busy, c_busy;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .ser_en(a_en), .ser_out(a_so), .ser_valid(a_sv), .bit_idx(a_idx),
    .word_done(a_wd), .busy(a_busy));

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .ser_en(b_en), .ser_out(b_so), .ser_valid(b_sv), .bit_idx(b_idx),
    .word_done(b_wd), .busy(b_busy));

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut_c (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .ser_en(c_en), .ser_out(c_so), .ser_valid(c_sv), .bit_idx(c_idx),
    .word_done(c_wd), .busy(c_busy));

  // Scoreboard entry: {word_done, bit_idx[2:0], ser_out}
  logic [4:0] qa[$], qb[$], qc[$];
  int checks = 0;
  int errors = 0;
  int vcnt[3];
  int wdcnt[3];
  logic mon_on   = 1'b0;
  logic stim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic [4:0] qfront(input int id);
    case (id)
      0:       return qa[0];
      1:       return qb[0];
      default: return qc[0];
    endcase
  endfunction

  task automatic qpop(input int id);
    case (id)
      0:       void'(qa.pop_front());
      1:       void'(qb.pop_front());
      default: void'(qc.pop_front());
    endcase
  endtask

  // stream is written in transmission order: stream[7] is the first bit on the wire
  task automatic push_stream(input int id, input logic [7:0] stream);
    logic [4:0] e;
    for (int i = 0; i < 8; i++) begin
      e = {(i == 7), 3'(i), stream[7-i]};
      case (id)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  task automatic wait_drain(input int id);
    int n = 0;
    while (qsize(id) != 0 && n < 64) begin
      tick();
      n++;
    end
    chk($sformatf("d%0d_drain_left", id), qsize(id), 0);
  endtask

  task automatic mon(input int id, input logic sv, input logic so, input logic en,
                     input logic wd, input logic [2:0] idx);
    logic [4:0] e;
    if (sv === 1'b1) begin
      vcnt[id]++;
      if (qsize(id) == 0) begin
        checks++;
        errors++;
        $display("FAIL d%0d_unexpected_bit actual ser_valid=1 required no bit at %0t", id, $time);
      end else begin
        e = qfront(id);
        chk($sformatf("d%0d_ser_out", id), so, e[0]);
        chk($sformatf("d%0d_bit_idx", id), idx, e[3:1]);
        if (en) begin
          chk($sformatf("d%0d_word_done", id), wd, e[4]);
          qpop(id);
        end else begin
          chk($sformatf("d%0d_stall_done", id), wd, 0);
        end
      end
    end else begin
      chk($sformatf("d%0d_idle_out", id), so, 0);
      chk($sformatf("d%0d_idle_done", id), wd, 0);
    end
    if (wd === 1'b1) wdcnt[id]++;
  endtask

  initial begin
    int v0, w0;
    reset = 1'b1;
    a_data = '0; b_data = '0; c_data = '0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vcnt[i] = 0;
      wdcnt[i] = 0;
    end

    fork
      begin
        while (!stim_done) begin
          @(negedge clk);
          if (mon_on) begin
            mon(0, a_sv, a_so, a_en, a_wd, a_idx);
            mon(1, b_sv, b_so, b_en, b_wd, b_idx);
            mon(2, c_sv, c_so, c_en, c_wd, c_idx);
          end
        end
      end
      begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", a_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_sv, 0);
        chk("rst_out", a_so, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_done", a_wd, 0);
        chk("rst_ready_gap_cfg", c_ready, 1);
        mon_on = 1'b1;

        // Single word 0xB4, MSB first
        a_data = 8'hB4; a_valid = 1'b1;
        push_stream(0, 8'b10110100);
        v0 = vcnt[0]; w0 = wdcnt[0];
        tick();
        a_valid = 1'b0;
        chk("t1_first_valid", a_sv, 1);
        chk("t1_ready_busy", a_ready, 0);
        wait_drain(0);
        chk("t1_valid_cycles", vcnt[0] - v0, 8);
        chk("t1_done_count", wdcnt[0] - w0, 1);
        chk("t1_idle_busy", a_busy, 0);
        chk("t1_idle_ready", a_ready, 1);

        // Back-to-back 0xB4 then 0x0F, no gap
        a_data = 8'hB4; a_valid = 1'b1;
        push_stream(0, 8'b10110100);
        push_stream(0, 8'b00001111);
        v0 = vcnt[0]; w0 = wdcnt[0];
        tick();
        a_data = 8'h0F;
        for (int i = 1; i <= 8; i++) begin
          chk($sformatf("t2_ready_c%0d", i), a_ready, (i == 8));
          chk($sformatf("t2_valid_c%0d", i), a_sv, 1);
          tick();
        end
        chk("t2_seam_valid", a_sv, 1);
        chk("t2_seam_idx", a_idx, 0);
        a_valid = 1'b0;
        wait_drain(0);
        chk("t2_valid_cycles", vcnt[0] - v0, 16);
        chk("t2_done_count", wdcnt[0] - w0, 2);

        // LSB first: 0x01 goes out as 1 then seven 0s
        b_data = 8'h01; b_valid = 1'b1;
        push_stream(1, 8'b10000000);
        v0 = vcnt[1];
        tick();
        b_valid = 1'b0;
        wait_drain(1);
        chk("t3_valid_cycles", vcnt[1] - v0, 8);

        // Stall three cycles on bit 2 of 0xFF
        a_data = 8'hFF; a_valid = 1'b1;
        push_stream(0, 8'b11111111);
        v0 = vcnt[0]; w0 = wdcnt[0];
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        chk("t4_pre_stall_idx", a_idx, 2);
        a_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
          tick();
          chk("t4_stall_idx", a_idx, 2);
          chk("t4_stall_out", a_so, 1);
        end
        a_en = 1'b1;
        wait_drain(0);
        chk("t4_valid_cycles", vcnt[0] - v0, 11);
        chk("t4_done_count", wdcnt[0] - w0, 1);

        // Three-cycle gap between 0xC3 and 0x5A
        c_data = 8'hC3; c_valid = 1'b1;
        push_stream(2, 8'b11000011);
        push_stream(2, 8'b01011010);
        v0 = vcnt[2];
        tick();
        c_data = 8'h5A;
        for (int i = 1; i <= 13; i++) begin
          chk($sformatf("t5_ready_c%0d", i), c_ready, (i == 12));
          chk($sformatf("t5_valid_c%0d", i), c_sv, (i <= 8 || i == 13));
          chk($sformatf("t5_busy_c%0d", i), c_busy, (i != 12));
          if (i >= 9 && i <= 11) chk($sformatf("t5_gap_out_c%0d", i), c_so, 0);
          if (i == 13) begin
            chk("t5_second_idx", c_idx, 0);
            c_valid = 1'b0;
          end
          tick();
        end
        wait_drain(2);
        chk("t5_valid_cycles", vcnt[2] - v0, 16);

        // Reset during bit 4 of 0xAA, with in_valid held through reset
        a_data = 8'hAA; a_valid = 1'b1;
        push_stream(0, 8'b10101010);
        w0 = wdcnt[0];
        tick();
        a_valid = 1'b0;
        repeat (4) tick();
        chk("t6_pre_reset_idx", a_idx, 4);
        reset = 1'b1;
        a_data = 8'h80; a_valid = 1'b1;
        tick();
        reset = 1'b0;
        qa.delete();
        chk("t6_rst_valid", a_sv, 0);
        chk("t6_rst_out", a_so, 0);
        chk("t6_rst_busy", a_busy, 0);
        chk("t6_rst_ready", a_ready, 1);
        chk("t6_rst_idx", a_idx, 0);
        push_stream(0, 8'b10000000);
        tick();
        a_valid = 1'b0;
        chk("t6_new_valid", a_sv, 1);
        chk("t6_new_idx", a_idx, 0);
        wait_drain(0);
        chk("t6_done_count", wdcnt[0] - w0, 1);

        repeat (6) tick();
        chk("end_qa", qsize(0), 0);
        chk("end_qb", qsize(1), 0);
        chk("end_qc", qsize(2), 0);
        stim_done = 1'b1;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage directly upstream of the team's "101" sequence-detector FSM.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on ser_out; the detector samples ser_out as its data_in.
- Drives ser_out low whenever no word bit is being presented, so the idle line never produces false detections downstream.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- GAP_CYCLES, 0, number of forced-zero idle cycles inserted after each word; legal range 0..15.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- reset  input  1  reset, synchronous, active-high.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_en  input  1  downstream advance enable; 0 stalls shifting.
- ser_out  output  1  serial bit; 0 when ser_valid=0.
- ser_valid  output  1  ser_out carries a word bit.
- bit_idx  output  $clog2(WIDTH)  index of the current bit within the word; 0 = first transmitted bit.
- word_done  output  1  one-cycle pulse when the last bit of a word is consumed.
- busy  output  1  state is not IDLE.

Behaviour:
- State machine with three states.
  - IDLE: in_ready=1, ser_valid=0, ser_out=0.
  - SHIFT: ser_valid=1, ser_out = current bit.
  - GAP: ser_valid=0, ser_out=0, gap counter running.
- Acceptance occurs when in_valid && in_ready at a rising edge. On acceptance, the shift register loads in_data (bit-reversed when MSB_FIRST=0), bit_idx goes to 0, and the state becomes SHIFT.
- Latency: first bit appears on ser_out in the cycle immediately after the acceptance edge. ser_out is taken directly from a register; there is no combinational path from in_data.
- A bit is consumed at each edge where state=SHIFT and ser_en=1; the register shifts and bit_idx increments.
- When ser_en=0, ser_out, ser_valid and bit_idx hold and nothing advances. ser_en is ignored in IDLE and GAP.
- Last-bit consumption (bit_idx=WIDTH-1 and ser_en=1):
  - word_done is asserted combinationally in that same cycle.
  - If GAP_CYCLES>0, the next state is GAP.
  - Otherwise the next state is IDLE, unless a new word is accepted in that same cycle.
- Back-to-back: when GAP_CYCLES=0, in_ready is also asserted during SHIFT when bit_idx=WIDTH-1 and ser_en=1. A word accepted there goes straight to SHIFT with no idle bit between words, so the stream is seamless.
- In all other SHIFT cycles, and in all GAP cycles, in_ready=0.
- GAP runs exactly GAP_CYCLES cycles, counted regardless of ser_en, then the state returns to IDLE.
- in_data is sampled only at acceptance. Changes while busy have no effect.
- Reset (at any time, including mid-word or mid-gap) forces the following at the next edge; the partial word is discarded:
  - state=IDLE, shift register=0, bit_idx=0, gap counter=0
  - ser_out=0, ser_valid=0, word_done=0, busy=0, in_ready=1
- in_valid asserted during reset is not accepted.
- No output value is X after the first reset edge.

Test Plan:
- WIDTH=8, MSB_FIRST=1, ser_en=1, accept 8'hB4 -> ser_out = 1,0,1,1,0,1,0,0 in cycles 1..8 after acceptance; ser_valid=1 on exactly those 8 cycles; word_done pulses in cycle 8; detector downstream reports 2 detections.
- Same config, in_valid held high with 8'hB4 then 8'h0F -> 16 consecutive ser_valid=1 cycles with no gap; in_ready=1 only on cycle 8; stream reads 10110100 00001111.
- MSB_FIRST=0, accept 8'h01 -> first ser_out=1, then seven 0s; bit_idx counts 0..7.
- Accept 8'hFF, drop ser_en to 0 for 3 cycles after bit 2 -> ser_out holds 1 and bit_idx holds 2 during the stall; total ser_valid-high cycles = 11; word_done fires once.
- GAP_CYCLES=3, two words offered back-to-back -> 3 cycles of ser_out=0, ser_valid=0, in_ready=0 between words; second word accepted in the first IDLE cycle after the gap.
- Assert reset during bit 4 of 8'hAA -> next cycle ser_valid=0, ser_out=0, busy=0, in_ready=1; a new word 8'h80 afterward serializes correctly starting from bit_idx 0.
